arbiter_8ch: RTL and testbench

ARBITER_8CH -- requirements
Module: arbiter_8ch

---
 rtl/arb_pkg.sv | 19 +
 rtl/prio_pick_8.sv | 30 +++
 rtl/arbiter_8ch.sv | 122 ++++++++++++
 tb/tb_arbiter_8ch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing for the 8-requester arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_pick_8.sv
// Combinational circular priority search over 8 requests starting at 'start'.
// DESCEND selects the walk direction (start, start-1, ... or start, start+1, ...).
module prio_pick_8
  import arb_pkg::*;
#(
  parameter bit DESCEND = 1'b0
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      idx = DESCEND ? (start - IDX_W'(i)) : (start + IDX_W'(i));
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_8ch.sv
// 8-channel IDLE/GRANT arbiter with hold timeout and registered one-hot grant.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed priority (7 highest).
module arbiter_8ch
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   gnt_id_nxt;
  logic               gnt_valid_nxt;
  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_id;
  logic               pick_found;
  logic               release_now;

`ifdef ROUND_ROBIN_EN
  localparam bit PICK_DESCEND = 1'b0;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  assign pick_start = ptr + IDX_W'(1);
`else
  localparam bit PICK_DESCEND = 1'b1;

  assign pick_start = IDX_W'(NUM_REQ - 1);
`endif

  prio_pick_8 #(
    .DESCEND (PICK_DESCEND)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .winner (pick_id),
    .found  (pick_found)
  );

  // Any combination of release causes collapses into one release edge.
  assign release_now = done | ~req[gnt_id] | (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    hold_cnt_nxt  = hold_cnt;
`ifdef ROUND_ROBIN_EN
    ptr_nxt       = ptr;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt     = ST_GRANT;
          gnt_nxt       = idx_to_onehot(pick_id);
          gnt_id_nxt    = pick_id;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = '0;
`ifdef ROUND_ROBIN_EN
          ptr_nxt       = pick_id;
`endif
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_nxt     = ST_IDLE;
          gnt_nxt       = '0;
          gnt_id_nxt    = '0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end else begin
          hold_cnt_nxt  = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
        hold_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr <= ptr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_arbiter_8ch.sv
// Scoreboard bench for arbiter_8ch: driver pushes model expectations, monitor pops and compares.
module tb_arbiter_8ch;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  always #5 clk = ~clk;

  arbiter_8ch #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current owner (-1 when idle), cycles already held.
  int m_owner = -1;
  int m_hold  = 0;
`ifdef ROUND_ROBIN_EN
  int m_ptr   = 7;
`endif

  function automatic int model_pick(input logic [7:0] r);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (m_ptr + k) % 8;
      if (r[i]) return i;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    int   w;
    if (rs) begin
      m_owner = -1;
      m_hold  = 0;
`ifdef ROUND_ROBIN_EN
      m_ptr   = 7;
`endif
    end else if (m_owner < 0) begin
      w = model_pick(r);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 0;
`ifdef ROUND_ROBIN_EN
        m_ptr   = w;
`endif
      end
    end else if (d || !r[m_owner] || m_hold == MAX_HOLD - 1) begin
      m_owner = -1;
      m_hold  = 0;
    end else begin
      m_hold++;
    end
    e.gnt   = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    e.id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.valid = (m_owner >= 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    model_step(r, d, rs);
  endtask

  task automatic expect_now(input string name, input logic [7:0] eg, input logic [2:0] eid,
                            input logic ev);
    @(posedge clk);
    #2;
    checks++;
    if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev) begin
      errors++;
      $display("FAIL %s: gnt=%h id=%0d valid=%b, expected gnt=%h id=%0d valid=%b",
               name, gnt, gnt_id, gnt_valid, eg, eid, ev);
    end
  endtask

  // Monitor: one expectation per clock edge, plus structural output invariants.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (gnt !== mon_e.gnt || gnt_id !== mon_e.id || gnt_valid !== mon_e.valid) begin
          errors++;
          $display("FAIL scoreboard @%0t: gnt=%h id=%0d valid=%b, expected gnt=%h id=%0d valid=%b",
                   $time, gnt, gnt_id, gnt_valid, mon_e.gnt, mon_e.id, mon_e.valid);
        end
        checks++;
        if (!$onehot0(gnt) || gnt_valid !== (|gnt) || (gnt != 8'h00 && gnt[gnt_id] !== 1'b1)) begin
          errors++;
          $display("FAIL invariant @%0t: gnt=%h id=%0d valid=%b, expected one-hot/zero gnt matching id and valid",
                   $time, gnt, gnt_id, gnt_valid);
        end
      end
    end
  end

  logic [7:0] rnd_req;
  logic [7:0] exp_g;
  logic [2:0] exp_id;
  logic       exp_v;

  initial begin
    // Reset
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    expect_now("reset", 8'h00, 3'd0, 1'b0);

    // Fixed-priority pick, then owner drops its request
    step(8'hA4, 1'b0, 1'b0);
`ifndef ROUND_ROBIN_EN
    expect_now("fixed_first", 8'h80, 3'd7, 1'b1);
`endif
    step(8'hA4, 1'b0, 1'b0);
    step(8'hA4, 1'b0, 1'b0);
    step(8'h24, 1'b0, 1'b0);
`ifndef ROUND_ROBIN_EN
    expect_now("fixed_release", 8'h00, 3'd0, 1'b0);
`endif
    step(8'h24, 1'b0, 1'b0);
`ifndef ROUND_ROBIN_EN
    expect_now("fixed_second", 8'h20, 3'd5, 1'b1);
`endif
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // All requesting, done held: grant every other cycle
    step(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      step(8'hFF, 1'b1, 1'b0);
      exp_v = (k % 2 == 0);
`ifdef ROUND_ROBIN_EN
      exp_id = exp_v ? 3'((k / 2) % 8) : 3'd0;
`else
      exp_id = exp_v ? 3'd7 : 3'd0;
`endif
      exp_g = exp_v ? (8'b1 << exp_id) : 8'h00;
      expect_now("all_req_done", exp_g, exp_id, exp_v);
    end
    step(8'h00, 1'b0, 1'b0);

    // Hold timeout: 4 granted cycles, 1 idle, repeat
    for (int k = 0; k < 12; k++) begin
      step(8'h01, 1'b0, 1'b0);
      exp_v = (k % 5 != 4);
      expect_now("hold_timeout", exp_v ? 8'h01 : 8'h00, 3'd0, exp_v);
    end

    // done and request drop together: one release
    step(8'h01, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    expect_now("double_release", 8'h00, 3'd0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    expect_now("double_release_after", 8'h00, 3'd0, 1'b0);

    // Reset mid-grant, then first grant after reset
    step(8'h08, 1'b0, 1'b0);
    expect_now("grant3", 8'h08, 3'd3, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b1, 1'b1);
    expect_now("rst_mid_grant", 8'h00, 3'd0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
`ifdef ROUND_ROBIN_EN
    expect_now("first_after_rst", 8'h01, 3'd0, 1'b1);
`else
    expect_now("first_after_rst", 8'h80, 3'd7, 1'b1);
`endif
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Random traffic with sticky requests, occasional done and reset
    rnd_req = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 8'($urandom);
      step(rnd_req, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0));
    end
    step(8'h00, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
